// File: rtl/serial_comp_ctrl.sv
// Bit-serial magnitude comparator: one shared 1-bit compare cell walks both
// operands MSB first and folds the per-bit outcome into a registered gt/eq/lt.

module comp_1bit (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic eq,
    output logic lt
);
    assign gt = a & ~b;
    assign eq = ~(a ^ b);
    assign lt = ~a & b;
endmodule

module serial_comp_ctrl #(
    parameter int unsigned W          = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic         gt,
    output logic         eq,
    output logic         lt
);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {IDLE, CMP} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  sa, sb;
    logic [CW-1:0] cnt;
    logic          decided, dec_gt;
    logic          bit_gt, bit_eq, bit_lt;
    logic          accept, last, finish;

    comp_1bit u_cmp (
        .a  (sa[W-1]),
        .b  (sb[W-1]),
        .gt (bit_gt),
        .eq (bit_eq),
        .lt (bit_lt)
    );

    always_comb begin
        accept = (state == IDLE) && start && !abort;
        last   = (cnt == CW'(W - 1));
        finish = (state == CMP) && !abort && ((EARLY_EXIT && !bit_eq) || last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CMP;
            CMP:  if (abort || finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CMP);
    end

    // The sticky decided flag keeps the first unequal bit's verdict when the
    // walk continues to the last bit; with early exit it never gets used.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa      <= '0;
            sb      <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            done    <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                sa      <= a_in;
                sb      <= b_in;
                cnt     <= '0;
                decided <= 1'b0;
                dec_gt  <= 1'b0;
            end else if ((state == CMP) && !abort) begin
                sa  <= sa << 1;
                sb  <= sb << 1;
                cnt <= cnt + CW'(1);
                if (!bit_eq && !decided) begin
                    decided <= 1'b1;
                    dec_gt  <= bit_gt;
                end
                if (finish) begin
                    done <= 1'b1;
                    gt   <= decided ? dec_gt : bit_gt;
                    eq   <= !decided && bit_eq;
                    lt   <= decided ? !dec_gt : bit_lt;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Bench for serial_comp_ctrl: six instances (W=1/8/13, both exit modes) share
// one stimulus stream and are checked every cycle against a transaction model.

module tb_serial_comp_ctrl;
    localparam int NI   = 6;
    localparam int WMAX = 13;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [WMAX-1:0] a_in  = '0;
    logic [WMAX-1:0] b_in  = '0;
    logic [NI-1:0]   busy_v, done_v, gt_v, eq_v, lt_v;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instances 0..2: early exit, W = 1/8/13; instances 3..5: full walk.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int WG = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 8 : 13);
        localparam bit EG = (g < 3);
        serial_comp_ctrl #(.W(WG), .EARLY_EXIT(EG)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .abort (abort),
            .a_in  (a_in[WG-1:0]),
            .b_in  (b_in[WG-1:0]),
            .busy  (busy_v[g]),
            .done  (done_v[g]),
            .gt    (gt_v[g]),
            .eq    (eq_v[g]),
            .lt    (lt_v[g])
        );
    end

    function automatic int wof(int i);
        return (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 8 : 13);
    endfunction

    function automatic bit eeof(int i);
        return i < 3;
    endfunction

    function automatic logic [2:0] res_of(logic [WMAX-1:0] a, logic [WMAX-1:0] b, int w);
        int av, bv;
        av = int'(a) & ((1 << w) - 1);
        bv = int'(b) & ((1 << w) - 1);
        if (av > bv) return 3'b100;
        if (av == bv) return 3'b010;
        return 3'b001;
    endfunction

    // Early exit stops at the most significant differing bit.
    function automatic int lat_of(logic [WMAX-1:0] a, logic [WMAX-1:0] b, int w, bit ee);
        int xv;
        xv = (int'(a) ^ int'(b)) & ((1 << w) - 1);
        if (ee && xv != 0) return w + 1 - $clog2(xv + 1);
        return w;
    endfunction

    bit       m_busy  [NI];
    bit       m_done  [NI];
    bit       m_valid [NI];
    bit [2:0] m_res   [NI];
    bit [2:0] m_pend  [NI];
    int       m_rem   [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_busy[i]  <= 1'b0;
                m_done[i]  <= 1'b0;
                m_valid[i] <= 1'b0;
                m_res[i]   <= 3'b000;
                m_rem[i]   <= 0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_busy[i]) begin
                    if (abort) begin
                        m_busy[i] <= 1'b0;
                    end else if (m_rem[i] == 1) begin
                        m_busy[i]  <= 1'b0;
                        m_done[i]  <= 1'b1;
                        m_valid[i] <= 1'b1;
                        m_res[i]   <= m_pend[i];
                    end else begin
                        m_rem[i] <= m_rem[i] - 1;
                    end
                end else if (start && !abort) begin
                    m_busy[i] <= 1'b1;
                    m_pend[i] <= res_of(a_in, b_in, wof(i));
                    m_rem[i]  <= lat_of(a_in, b_in, wof(i), eeof(i));
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Every stimulus step passes through here, so the model compare runs each cycle.
    task automatic tick();
        logic [4:0] act, exp;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            act = {busy_v[i], done_v[i], gt_v[i], eq_v[i], lt_v[i]};
            exp = {m_busy[i], m_done[i], m_res[i]};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle inst%0d busy/done/gt/eq/lt got %b want %b at %0t", i, act, exp, $time);
            end
            if (m_valid[i]) begin
                checks++;
                if ($countones({gt_v[i], eq_v[i], lt_v[i]}) != 1) begin
                    errors++;
                    $display("FAIL onehot inst%0d got %b want one-hot", i, {gt_v[i], eq_v[i], lt_v[i]});
                end
            end
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60; n++) begin
            if (busy_v == '0) break;
            tick();
        end
        chk("idle_timeout", 32'(busy_v), 32'd0);
    endtask

    task automatic run(logic [7:0] a, logic [7:0] b, int k1, int k0, logic [2:0] r);
        int lat1, lat0;
        wait_idle();
        a_in  = {5'b0, a};
        b_in  = {5'b0, b};
        start = 1'b1;
        tick();
        start = 1'b0;
        lat1  = -1;
        lat0  = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done_v[1] && lat1 < 0) lat1 = n;
            if (done_v[4] && lat0 < 0) lat0 = n;
        end
        chk("lat_ee1", 32'(lat1), 32'(k1));
        chk("lat_ee0", 32'(lat0), 32'(k0));
        chk("res_ee1", 32'({gt_v[1], eq_v[1], lt_v[1]}), 32'(r));
        chk("res_ee0", 32'({gt_v[4], eq_v[4], lt_v[4]}), 32'(r));
    endtask

    initial begin
        int n, ndone;

        // Reset for two edges with start held high.
        rst_n = 1'b0;
        start = 1'b1;
        a_in  = 13'h80;
        tick();
        tick();
        chk("rst_state", 32'({busy_v, done_v, gt_v, eq_v, lt_v}), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        chk("rst_start_ignored", 32'(busy_v), 32'd0);

        run(8'h80, 8'h7F, 1, 8, 3'b100);
        run(8'hA5, 8'hA4, 8, 8, 3'b100);
        run(8'h10, 8'h20, 3, 8, 3'b001);
        run(8'h3C, 8'h3C, 8, 8, 3'b010);

        // Abort sampled at the third edge after the accepting edge.
        wait_idle();
        a_in  = 13'h000;
        b_in  = 13'h0FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy_v[4]), 32'd0);
        chk("abort_res_held", 32'({gt_v[4], eq_v[4], lt_v[4]}), 32'(3'b010));
        chk("abort_ee1_res", 32'({gt_v[1], eq_v[1], lt_v[1]}), 32'(3'b001));
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_v[4]) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        wait_idle();
        a_in  = 13'h80;
        b_in  = 13'h7F;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_rejected", 32'(busy_v), 32'd0);

        // Start held every cycle: ignored while busy, accepted in the done cycle.
        wait_idle();
        a_in  = 13'hA5;
        b_in  = 13'hA4;
        start = 1'b1;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done_v[4]) begin
                n = i;
                break;
            end
        end
        chk("b2b_first_done", 32'(n), 32'd9);
        tick();
        chk("b2b_busy_reassert", 32'(busy_v[4]), 32'd1);
        chk("b2b_done_cleared", 32'(done_v[4]), 32'd0);
        n = 0;
        for (int i = 2; i <= 30; i++) begin
            tick();
            if (done_v[4]) begin
                n = i;
                break;
            end
        end
        chk("b2b_period", 32'(n), 32'd9);
        start = 1'b0;

        // Reset in the middle of a compare discards it.
        wait_idle();
        a_in  = 13'h000;
        b_in  = 13'h0FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_state", 32'({busy_v, done_v, gt_v, eq_v, lt_v}), 32'd0);

        for (int it = 0; it < 2000; it++) begin
            a_in = 13'($urandom);
            case ($urandom_range(0, 3))
                0:       b_in = a_in;
                1:       b_in = a_in ^ (13'd1 << $urandom_range(0, 12));
                default: b_in = 13'($urandom);
            endcase
            start = 1'b1;
            abort = ($urandom_range(0, 31) == 0);
            tick();
            start = 1'b0;
            abort = 1'b0;
            repeat ($urandom_range(0, 14)) begin
                abort = ($urandom_range(0, 63) == 0);
                tick();
            end
            abort = 1'b0;
        end

        wait_idle();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
